// File: rtl/mrt_pkg.sv
// Shared types and constants for the MinRoot datapath: coefficient field,
// Montgomery constants, penta-root exponent and FSM states.
package mrt_pkg;

    localparam int unsigned CoeffW    = 16;
    localparam int unsigned NumCoeffs = 2;

    // p = 12289, R = 2^16; p-1 is not divisible by 5, so x^5 is a bijection.
    localparam logic [CoeffW-1:0] Modulus   = 16'd12289;
    localparam logic [CoeffW-1:0] ModNegInv = 16'd12287;

    localparam int unsigned MulLatency = 3;

    // 5 * 7373 = 3 * (p-1) + 1, so x^7373 is the fifth root.
    localparam int unsigned             PentaExpBits = 13;
    localparam logic [PentaExpBits-1:0] PentaExp     = 13'd7373;

    typedef logic [CoeffW-1:0]           coeff_t;
    typedef coeff_t [NumCoeffs-1:0]      poly_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    // REDC(a*b); inputs below 2p keep the pre-subtraction value below 2p.
    function automatic coeff_t mont_redc(input coeff_t a, input coeff_t b);
        logic [2*CoeffW-1:0] t;
        coeff_t              m;
        coeff_t              r;
        t = 32'(a) * 32'(b);
        m = t[CoeffW-1:0] * ModNegInv;
        r = 16'((t + 32'(m) * 32'(Modulus)) >> CoeffW);
        return (r >= Modulus) ? (r - Modulus) : r;
    endfunction

endpackage

// File: rtl/mrt_mont_mul.sv
// Coefficient-wise Montgomery product of two polynomials in evaluation form,
// fixed latency: result-valid exactly Latency cycles after valid_i.
module mrt_mont_mul
    import mrt_pkg::*;
#(
    parameter int unsigned Latency = MulLatency
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  valid_i,
    input  poly_t a_i,
    input  poly_t b_i,
    output poly_t r_o,
    output logic  valid_o
);

    poly_t                prod;
    poly_t [Latency-1:0]  pipe_q;
    logic  [Latency-1:0]  vld_q;

    for (genvar gi = 0; gi < NumCoeffs; gi++) begin : g_coeff
        assign prod[gi] = mont_redc(a_i[gi], b_i[gi]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
            vld_q  <= '0;
        end else begin
            pipe_q[0] <= prod;
            vld_q[0]  <= valid_i;
            for (int i = 1; i < Latency; i++) begin
                pipe_q[i] <= pipe_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign r_o     = pipe_q[Latency-1];
    assign valid_o = vld_q[Latency-1];

endmodule

// File: rtl/mrt_penta_root.sv
// Penta-root responder: computes x^Exp by MSB-first square-and-multiply on a
// single shared Montgomery multiplier, with slot-synchronised acceptance.
module mrt_penta_root
    import mrt_pkg::*;
#(
    parameter int unsigned        SyncPeriod = 8,
    parameter int unsigned        MulLatency = mrt_pkg::MulLatency,
    parameter int unsigned        ExpBits    = mrt_pkg::PentaExpBits,
    parameter logic [ExpBits-1:0] Exp        = mrt_pkg::PentaExp
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  start_i,
    input  poly_t x_i,
    output logic  sync_o,
    output logic  done_o,
    output poly_t x_o,
    output logic  busy_o,
    output logic  err_o
);

    localparam int unsigned SlotW = (SyncPeriod > 1) ? $clog2(SyncPeriod) : 1;
    localparam int unsigned BitW  = $clog2(ExpBits);

    state_e            state_q, state_d;
    logic [SlotW-1:0]  slot_q, slot_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    poly_t             base_q, base_d;
    poly_t             acc_q, acc_d;
    poly_t             xo_q, xo_d;

    logic              accept;
    logic              mul_valid;
    poly_t             mul_r;

    assign sync_o = (state_q == IDLE) && (slot_q == '0);
    assign done_o = (state_q == DONE);
    assign busy_o = (state_q == ISSUE) || (state_q == WAIT);
    assign err_o  = err_q;
    assign x_o    = xo_q;
    assign accept = start_i && (sync_o || done_o);

    // A pending multiply uses the base; otherwise the accumulator is squared.
    mrt_mont_mul #(
        .Latency (MulLatency)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (state_q == ISSUE),
        .a_i     (acc_q),
        .b_i     (pend_q ? base_q : acc_q),
        .r_o     (mul_r),
        .valid_o (mul_valid)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = (slot_q == SlotW'(SyncPeriod - 1)) ? '0 : slot_q + 1'b1;
        bit_d   = bit_q;
        pend_d  = pend_q;
        err_d   = err_q | (start_i & busy_o);
        base_d  = base_q;
        acc_d   = acc_q;
        xo_d    = xo_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    base_d  = x_i;
                    acc_d   = x_i;
                    bit_d   = BitW'(ExpBits - 2);
                    pend_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mul_valid) begin
                    acc_d = mul_r;
                    if (!pend_q && Exp[bit_q]) begin
                        pend_d  = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        pend_d = 1'b0;
                        if (bit_q == '0) begin
                            xo_d    = mul_r;
                            state_d = DONE;
                        end else begin
                            bit_d   = bit_q - 1'b1;
                            state_d = ISSUE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            slot_q  <= SlotW'(1);
            bit_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            base_q  <= '0;
            acc_q   <= '0;
            xo_q    <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            xo_q    <= xo_d;
        end
    end

endmodule

// File: tb/tb_mrt_penta_root.sv
// Directed bench for mrt_penta_root: one instance with Exp=19/latency 4 and one
// with the package defaults checked against the fifth-power identity.
module tb_mrt_penta_root;

    localparam longint P    = 12289;
    localparam longint RMOD = 65536;
    localparam int     LatA = 31;   // N=6 ops of 5 cycles, +1
    localparam int     LatB = 77;   // N=19 ops of 4 cycles, +1

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic            start_a, start_b;
    mrt_pkg::poly_t  x_a, x_b, xo_a, xo_b;
    logic            sync_a, done_a, busy_a, err_a;
    logic            sync_b, done_b, busy_b, err_b;

    mrt_penta_root #(
        .SyncPeriod (8),
        .MulLatency (4),
        .ExpBits    (5),
        .Exp        (5'b10011)
    ) u_dut_a (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_a),
        .x_i     (x_a),
        .sync_o  (sync_a),
        .done_o  (done_a),
        .x_o     (xo_a),
        .busy_o  (busy_a),
        .err_o   (err_a)
    );

    mrt_penta_root u_dut_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_b),
        .x_i     (x_b),
        .sync_o  (sync_b),
        .done_o  (done_b),
        .x_o     (xo_b),
        .busy_o  (busy_b),
        .err_o   (err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint modpow(input longint b, input longint e);
        longint r  = 1;
        longint bb = b % P;
        longint ee = e;
        while (ee > 0) begin
            if ((ee % 2) == 1) r = (r * bb) % P;
            bb = (bb * bb) % P;
            ee = ee / 2;
        end
        return r;
    endfunction

    function automatic mrt_pkg::coeff_t to_mont(input longint v);
        return 16'((v % P) * RMOD % P);
    endfunction

    function automatic longint from_mont(input longint v);
        return (v % P) * modpow(RMOD % P, P - 2) % P;
    endfunction

    function automatic logic win(input bit which);
        return which ? (sync_b | done_b) : (sync_a | done_a);
    endfunction

    task automatic set_start(input bit which, input logic v);
        if (which) start_b = v;
        else       start_a = v;
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input bit which, input mrt_pkg::poly_t x, input int poke_at,
                          output mrt_pkg::poly_t res, output int lat);
        int n = 0;
        if (which) x_b = x;
        else       x_a = x;
        set_start(which, 1'b1);
        while (!win(which) && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        chk("accept_window", win(which), 1'b1);
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
            set_start(which, lat == poke_at);
            if (poke_at > 0 && lat == poke_at)     chk("err_before_poke", err_a, 1'b0);
            if (poke_at > 0 && lat == poke_at + 1) chk("err_after_poke", err_a, 1'b1);
        end while (!(which ? done_b : done_a) && lat < 400);
        set_start(which, 1'b0);
        res = which ? xo_b : xo_a;
        $display("op dut=%0d x=%h res=%h lat=%0d", which, x, res, lat);
    endtask

    mrt_pkg::poly_t res, x;
    int             lat;

    initial begin
        rst_ni  = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        x_a     = '0;
        x_b     = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_sync", sync_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_err",  err_a,  1'b0);
        chk("rst_xo",   xo_a,   '0);

        // Idle sync slots: cycles 7, 15, 23 after reset release.
        rst_ni = 1'b1;
        for (int k = 0; k < 24; k++) begin
            chk("idle_sync", sync_a, (k % 8) == 7);
            chk("idle_outs", {done_a, busy_a, err_a}, 3'b000);
            @(negedge clk_i);
        end

        // Montgomery one stays one.
        x = {to_mont(1), to_mont(1)};
        run_op(1'b0, x, 0, res, lat);
        chk("one_lat", lat, LatA);
        chk("one_c0", res[0], to_mont(1));
        chk("one_c1", res[1], to_mont(1));
        chk("sync_in_done", sync_a, 1'b0);

        // Back-to-back accept in the done cycle.
        x = {to_mont(5), to_mont(2)};
        run_op(1'b0, x, 0, res, lat);
        chk("b2b_lat", lat, LatA);
        chk("b2b_c0", res[0], to_mont(modpow(2, 19)));
        chk("b2b_c1", res[1], to_mont(modpow(5, 19)));

        // Start pulse without a sync slot is ignored.
        @(negedge clk_i);
        for (int n = 0; n < 10 && sync_a; n++) @(negedge clk_i);
        x_a     = {to_mont(7), to_mont(7)};
        start_a = 1'b1;
        chk("pulse_no_sync", sync_a, 1'b0);
        @(negedge clk_i);
        start_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("ignored_busy", busy_a, 1'b0);
            chk("ignored_err",  err_a,  1'b0);
            @(negedge clk_i);
        end
        chk("xo_held", xo_a, {to_mont(modpow(5, 19)), to_mont(modpow(2, 19))});

        // Start while busy: sticky error, result unaffected.
        x = {to_mont(11), to_mont(3)};
        run_op(1'b0, x, 5, res, lat);
        chk("err_lat", lat, LatA);
        chk("err_c0", res[0], to_mont(modpow(3, 19)));
        chk("err_c1", res[1], to_mont(modpow(11, 19)));
        chk("err_sticky", err_a, 1'b1);

        // Reset during WAIT.
        @(negedge clk_i);
        x_a     = {to_mont(9), to_mont(6)};
        start_a = 1'b1;
        for (int n = 0; n < 20 && !sync_a; n++) @(negedge clk_i);
        chk("rstw_accept", sync_a, 1'b1);
        @(negedge clk_i);
        start_a = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rstw_busy_pre", busy_a, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("rstw_busy", busy_a, 1'b0);
        chk("rstw_done", done_a, 1'b0);
        chk("rstw_err",  err_a,  1'b0);
        chk("rstw_xo",   xo_a,   '0);
        chk("rstw_sync", sync_a, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("rstw_quiet", {done_a, busy_a}, 2'b00);
            @(negedge clk_i);
        end
        x = {to_mont(9), to_mont(6)};
        run_op(1'b0, x, 0, res, lat);
        chk("rstw_lat", lat, LatA);
        chk("rstw_c0", res[0], to_mont(modpow(6, 19)));
        chk("rstw_c1", res[1], to_mont(modpow(9, 19)));

        // Default exponent: fifth power of the result recovers the input.
        for (int i = 0; i < 20; i++) begin
            x[0] = 16'($urandom_range(1, 2 * P - 1));
            x[1] = 16'($urandom_range(1, 2 * P - 1));
            run_op(1'b1, x, 0, res, lat);
            chk("root_lat", lat, LatB);
            chk("root_c0", modpow(from_mont(res[0]), 5), from_mont(x[0]));
            chk("root_c1", modpow(from_mont(res[1]), 5), from_mont(x[1]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
